// File: rtl/bar_scanner.sv
// Bar-graph frame streamer: snapshots 16 magnitudes and streams scaled, saturated bar heights.
// Optional peak-hold registers are enabled with `define BAR_SCANNER_PEAK_HOLD_EN.
module bar_scanner #(
   parameter int SHIFT      = 8,
   parameter int MAX_HEIGHT = 200,
   parameter int DECAY      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] input_array [16],
   input  logic        frame_start,
   output logic        bar_valid,
   input  logic        bar_ready,
   output logic [3:0]  bar_index,
   output logic [7:0]  bar_height,
   output logic [7:0]  bar_peak,
   output logic        busy,
   output logic        frame_done,
   output logic        frame_overrun
);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] snap_q [16];
   logic [15:0] snap_d [16];
   logic        overrun_q, overrun_d;
   logic [15:0] shifted;
   logic [7:0]  height;
   logic        beat;

   if (MAX_HEIGHT < 0 || MAX_HEIGHT > 255 || SHIFT < 0 || SHIFT > 15 ||
       DECAY < 0 || DECAY > 255) begin : g_bad_params
      $error("bar_scanner: parameter out of range");
   end

   // Saturation compares the full-width shifted value so large entries never wrap.
   always_comb begin
      shifted = snap_q[idx_q] >> SHIFT;
      height  = (shifted > 16'(MAX_HEIGHT)) ? 8'(MAX_HEIGHT) : shifted[7:0];
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      snap_d    = snap_q;
      overrun_d = overrun_q;
      beat      = (state_q == STREAM) && bar_ready;
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               snap_d  = input_array;
               idx_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (frame_start) overrun_d = 1'b1;
            if (beat) begin
               if (idx_q == 4'd15) state_d = DONE;
               else                idx_d   = idx_q + 4'd1;
            end
         end
         DONE: begin
            if (frame_start) overrun_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         overrun_q <= 1'b0;
         snap_q    <= '{default: '0};
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         overrun_q <= overrun_d;
         snap_q    <= snap_d;
      end
   end

   assign bar_valid     = (state_q == STREAM);
   assign bar_index     = idx_q;
   assign bar_height    = bar_valid ? height : 8'd0;
   assign busy          = (state_q != IDLE);
   assign frame_done    = (state_q == DONE);
   assign frame_overrun = overrun_q;

`ifdef BAR_SCANNER_PEAK_HOLD_EN
   logic [7:0] peak_q [16];
   logic [7:0] peak_d [16];
   logic [7:0] decayed;
   logic [7:0] peak_new;

   // The presented peak is the value that will be written back if this beat is accepted.
   always_comb begin
      decayed  = (32'(peak_q[idx_q]) > DECAY) ? (peak_q[idx_q] - 8'(DECAY)) : 8'd0;
      peak_new = (height > decayed) ? height : decayed;
      peak_d   = peak_q;
      if (beat) peak_d[idx_q] = peak_new;
   end

   always_ff @(posedge clk) begin
      if (reset) peak_q <= '{default: '0};
      else       peak_q <= peak_d;
   end

   assign bar_peak = bar_valid ? peak_new : 8'd0;
`else
   assign bar_peak = bar_height;
`endif

endmodule

// File: doc/bar_scanner.md
BAR_SCANNER -- requirements
Module: bar_scanner

Interface
REQ-001 SHALL have parameter SHIFT, default 8: right-shift applied to each 16-bit entry before display scaling.
REQ-002 SHALL have parameter MAX_HEIGHT, default 200: saturation ceiling for bar height; legal range 0..255.
REQ-003 SHALL have parameter DECAY, default 4: peak decrement per frame (peak-hold build only).
REQ-004 SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 input_array  input  [15:0] x 16 entries  per-bar magnitudes from the switch/input conversion stage.
REQ-008 frame_start  input  1  single-cycle request to snapshot and stream one frame.
REQ-009 bar_valid  output  1  bar_index/bar_height/bar_peak valid this cycle.
REQ-010 bar_ready  input  1  downstream renderer accepts the beat.
REQ-011 bar_index  output  4  bar number, 0..15.
REQ-012 bar_height  output  8  scaled, saturated height.
REQ-013 bar_peak  output  8  peak-hold height.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after bar 15 is accepted.
REQ-016 frame_overrun  output  1  sticky flag: a frame_start arrived while busy.

Function
REQ-017 FSM SHALL have exactly three states: IDLE, STREAM, DONE.
REQ-018 IDLE, frame_start=1: all 16 entries SHALL be captured into a snapshot on that edge, idx cleared to 0, next state STREAM.
REQ-019 Latency: frame_start sampled at edge N SHALL give bar_valid=1 with bar_index=0 after edge N.
REQ-020 STREAM SHALL drive bar_valid=1, bar_index=idx, bar_height=min(snapshot[idx]>>SHIFT, MAX_HEIGHT).
REQ-021 A beat SHALL transfer only on bar_valid&&bar_ready; when idx<15, idx increments; when idx=15, next state is DONE.
REQ-022 While bar_valid&&!bar_ready, bar_index, bar_height and bar_peak SHALL hold stable.
REQ-023 DONE SHALL assert frame_done for exactly one cycle with bar_valid=0, then return to IDLE.
REQ-024 frame_start in STREAM or DONE SHALL be ignored, SHALL set frame_overrun, and SHALL leave the snapshot untouched.
REQ-025 Changes on input_array after capture SHALL NOT affect the frame in flight.
REQ-026 Height arithmetic: shift first, then compare against MAX_HEIGHT at full width; truncation before the compare is not allowed.
REQ-027 Minimum frame time with bar_ready held high SHALL be 17 cycles from the first bar_valid to frame_done.

Reset
REQ-028 reset SHALL take priority over all other inputs, including mid-frame, and SHALL force IDLE with idx=0.
REQ-029 After the reset edge: bar_valid=0, bar_index=0, bar_height=0, bar_peak=0, busy=0, frame_done=0, frame_overrun=0.
REQ-030 reset SHALL clear the snapshot and all peak registers to 0.

Configuration
REQ-031 Macro BAR_SCANNER_PEAK_HOLD_EN defined: the block SHALL hold 16 peak registers of 8 bits each.
REQ-032 With the macro, on each accepted beat: peak[idx] <= max(height, sat0(peak[idx]-DECAY)), where sat0 floors at 0.
REQ-033 With the macro, bar_peak SHALL present that updated value combinationally during bar_valid.
REQ-034 Macro undefined: no peak registers; bar_peak SHALL equal bar_height; the port list is unchanged.

Verification
REQ-035 Reset; input_array[i]=i<<8; frame_start; bar_ready=1 -> 16 consecutive beats with index 0..15 and height 0..15, then frame_done one cycle after bar 15.
REQ-036 Beat idx=5, bar_ready=0 for 3 cycles -> index=5 and height=5 held stable for all 3 cycles, then bar 6 follows after acceptance.
REQ-037 input_array[2]=0xFFFF with defaults -> bar 2 height=200; input_array[3]=0xC7FF -> height=199.
REQ-038 Second frame_start at the bar-4 beat, plus input_array rewritten mid-frame -> frame_overrun=1, heights from the original snapshot, exactly one frame_done.
REQ-039 reset asserted at the bar-9 beat -> the next cycle shows bar_valid=0, busy=0, frame_done never asserted; a new frame_start restarts at index 0.
REQ-040 With BAR_SCANNER_PEAK_HOLD_EN: frame 1 bar 3 height=100, then frame 2 bar 3 height=0 -> bar_peak=100, then 96; without the macro -> bar_peak=0 in frame 2.
